axi3_rd_arbiter: RTL and testbench



---
 rtl/axi3_rd_arbiter_pkg.sv | 29 ++
 rtl/axi3_rd_arbiter_if.sv | 75 +++++++
 rtl/axi3_rd_arbiter_grant.sv | 31 +++
 rtl/axi3_rd_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_axi3_rd_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi3_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi3_rd_arbiter_pkg
// Shared constants for the two-requester AXI3 read arbiter:
//   - FSM state encoding (ST_IDLE / ST_AR / ST_R)
//   - AXI field constants (BURST_INCR, RESP_OKAY)
//   - requester id constants (ID_M0 / ID_M1) and a grant-to-id helper
// ---------------------------------------------------------------------------
package axi3_rd_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_AR      = 2'd1;
    localparam logic [1:0] ST_R       = 2'd2;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam logic [3:0] ID_M0      = 4'd0;
    localparam logic [3:0] ID_M1      = 4'd1;

    // Map the 1-bit grant (0 = m0, 1 = m1) onto the AXI transaction id.
    function automatic logic [3:0] grant_to_id(input logic grant);
        if (grant) begin
            return ID_M1;
        end else begin
            return ID_M0;
        end
    endfunction

endpackage

// File: rtl/axi3_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi3_rd_arbiter_if
// Bundles both requester ports and the core-side AXI3 read channel (AR/R)
// of the read arbiter.
//   modport master : the arbiter (consumes requests, drives AR, sinks R)
//   modport slave  : the environment (requesters + AXI read slave)
// Signals: m0_*/m1_* request and return-data ports, ar* address channel,
//          r* data channel, rd_err sticky error flag.
// ---------------------------------------------------------------------------
interface axi3_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              m0_req_valid;
    logic              m0_req_ready;
    logic [ADDR_W-1:0] m0_req_addr;
    logic [7:0]        m0_req_len;
    logic [2:0]        m0_req_size;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rlast;

    logic              m1_req_valid;
    logic              m1_req_ready;
    logic [ADDR_W-1:0] m1_req_addr;
    logic [7:0]        m1_req_len;
    logic [2:0]        m1_req_size;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rlast;

    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic              rd_err;

    modport master (
        input  m0_req_valid, m0_req_addr, m0_req_len, m0_req_size,
        output m0_req_ready, m0_rvalid, m0_rdata, m0_rlast,
        input  m1_req_valid, m1_req_addr, m1_req_len, m1_req_size,
        output m1_req_ready, m1_rvalid, m1_rdata, m1_rlast,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output rd_err
    );

    modport slave (
        output m0_req_valid, m0_req_addr, m0_req_len, m0_req_size,
        input  m0_req_ready, m0_rvalid, m0_rdata, m0_rlast,
        output m1_req_valid, m1_req_addr, m1_req_len, m1_req_size,
        input  m1_req_ready, m1_rvalid, m1_rdata, m1_rlast,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  rd_err
    );
endinterface

// File: rtl/axi3_rd_arbiter_grant.sv
// ---------------------------------------------------------------------------
// axi3_rd_grant
// Combinational winner select between the two read requesters.
//   i_req_valid[1:0] : request valids (bit 0 = m0, bit 1 = m1)
//   i_ptr            : requester that wins a tie (0 = m0, 1 = m1)
//   o_grant[1:0]     : one-hot winner, all-zero when nobody requests
// Fixed and round-robin priority share this block; they differ only in how
// the top drives i_ptr.
// ---------------------------------------------------------------------------
module axi3_rd_grant (
    input  logic [1:0] i_req_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);
    // One-hot winner; only a tie consults the pointer.
    always_comb begin
        o_grant = 2'b00;
        case (i_req_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11: begin
                if (i_ptr) begin
                    o_grant = 2'b10;
                end else begin
                    o_grant = 2'b01;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/axi3_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi3_rd_arbiter
// Shares the core's single AXI3 read channel between the instruction-fetch
// refill path (m0) and the data-side refill / uncached-load path (m1).
// One outstanding transaction; R beats are steered back with zero latency.
// Ports:
//   aclk    : clock
//   aresetn : asynchronous active-low reset
//   bus     : axi3_rd_arbiter_if.master (requesters, AR, R, rd_err)
// Build option:
//   AXI_RD_ARB_RR_EN defined   -> round-robin tie-break with a 1-bit pointer
//   AXI_RD_ARB_RR_EN undefined -> fixed priority, m1 wins ties
// ---------------------------------------------------------------------------
module axi3_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic          aclk,
    input logic          aresetn,
    axi3_rd_arbiter_if.master bus
);
    import axi3_rd_arbiter_pkg::*;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic              r_rd_err;

    logic [1:0]        w_win;
    logic              w_ptr;
    logic              w_idle;
    logic              w_accept;
    logic              w_beat;
    logic              w_match;
    logic              w_done;
    logic              w_rd_err_set;

    // req_ready is combinational; gating with aresetn keeps it low in reset.
    assign w_idle   = (r_state == ST_IDLE) && aresetn;
    assign w_accept = w_idle && (w_win != 2'b00);
    assign w_beat   = (r_state == ST_R) && bus.rvalid;
    assign w_match  = w_beat && (bus.rid == grant_to_id(r_grant));
    assign w_done   = w_match && bus.rlast;

    // Unexpected id, error response, or any beat outside the R phase
    // (e.g. a burst that was cut short by reset) is flagged.
    assign w_rd_err_set = (w_beat && !w_match)
                        || (w_match && (bus.rresp != RESP_OKAY))
                        || (bus.rvalid && (r_state != ST_R));

`ifdef AXI_RD_ARB_RR_EN
    logic r_ptr;

    // Round-robin pointer: hands the tie to the other requester after each burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr <= 1'b0;
        end else if (w_done) begin
            r_ptr <= ~r_grant;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign w_ptr = r_ptr;
`else
    // Fixed priority: the data side always wins a tie.
    assign w_ptr = 1'b1;
`endif

    axi3_rd_grant u_grant (
        .i_req_valid ({bus.m1_req_valid, bus.m0_req_valid}),
        .i_ptr       (w_ptr),
        .o_grant     (w_win)
    );

    // FSM next-state: IDLE -> AR on request handshake, AR -> R on arready,
    // R -> IDLE on the granted requester's last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_AR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_AR: begin
                if (bus.arready) begin
                    w_state_nxt = ST_R;
                end else begin
                    w_state_nxt = ST_AR;
                end
            end
            ST_R: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_R;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winner and its request fields at the handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_len   <= 8'd0;
            r_size  <= 3'd0;
        end else if (w_accept) begin
            r_grant <= w_win[1];
            if (w_win[1]) begin
                r_addr <= bus.m1_req_addr;
                r_len  <= bus.m1_req_len;
                r_size <= bus.m1_req_size;
            end else begin
                r_addr <= bus.m0_req_addr;
                r_len  <= bus.m0_req_len;
                r_size <= bus.m0_req_size;
            end
        end else begin
            r_grant <= r_grant;
        end
    end

    // Sticky read error flag, cleared only by reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_err <= 1'b0;
        end else if (w_rd_err_set) begin
            r_rd_err <= 1'b1;
        end else begin
            r_rd_err <= r_rd_err;
        end
    end

    // Output drive: request ready, AR channel, zero-latency R steering.
    always_comb begin
        bus.m0_req_ready = w_idle && w_win[0];
        bus.m1_req_ready = w_idle && w_win[1];

        bus.arvalid = (r_state == ST_AR);
        bus.arid    = grant_to_id(r_grant);
        bus.araddr  = r_addr;
        bus.arlen   = r_len;
        bus.arsize  = r_size;
        bus.arburst = BURST_INCR;
        bus.arlock  = 2'b00;
        bus.arcache = 4'b0000;
        bus.arprot  = 3'b000;
        bus.rready  = (r_state == ST_R);

        bus.m0_rvalid = w_match && !r_grant;
        bus.m1_rvalid = w_match && r_grant;
        bus.m0_rlast  = bus.m0_rvalid && bus.rlast;
        bus.m1_rlast  = bus.m1_rvalid && bus.rlast;
        bus.m0_rdata  = {DATA_W{1'b0}};
        bus.m1_rdata  = {DATA_W{1'b0}};
        if (bus.m0_rvalid) begin
            bus.m0_rdata = bus.rdata;
        end else begin
            bus.m0_rdata = {DATA_W{1'b0}};
        end
        if (bus.m1_rvalid) begin
            bus.m1_rdata = bus.rdata;
        end else begin
            bus.m1_rdata = {DATA_W{1'b0}};
        end

        bus.rd_err = r_rd_err;
    end

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi3_rd_arbiter
// Directed bench for axi3_rd_arbiter. Tie-break expectations follow the
// AXI_RD_ARB_RR_EN build option.
// ---------------------------------------------------------------------------
module tb_axi3_rd_arbiter;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    always #5 aclk = ~aclk;

    axi3_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi3_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Wait for a request handshake and check who won it.
    task automatic accept(input int exp_who);
        int who;
        who = -1;
        for (int k = 0; k < 8 && who < 0; k++) begin
            #1;
            if (bus.m0_req_ready) begin
                who = 0;
            end else if (bus.m1_req_ready) begin
                who = 1;
            end else begin
                tick();
            end
        end
        check_eq("grant_winner", 64'(who), 64'(exp_who));
        check_eq("ready_onehot", 64'(bus.m0_req_ready & bus.m1_req_ready), 64'd0);
        tick();
    endtask

    task automatic ar_phase(input int who, input logic [31:0] addr, input logic [7:0] len,
                            input int stall);
        for (int k = 0; k <= stall; k++) begin
            check_eq("arvalid", 64'(bus.arvalid), 64'd1);
            check_eq("arid", 64'(bus.arid), 64'(who));
            check_eq("araddr", 64'(bus.araddr), 64'(addr));
            check_eq("arlen", 64'(bus.arlen), 64'(len));
            check_eq("req_ready_busy", 64'(bus.m0_req_ready | bus.m1_req_ready), 64'd0);
            if (k == stall) begin
                bus.arready = 1'b1;
            end
            tick();
        end
        bus.arready = 1'b0;
        check_eq("arvalid_drop", 64'(bus.arvalid), 64'd0);
        check_eq("rready_in_r", 64'(bus.rready), 64'd1);
    endtask

    task automatic r_phase(input int who, input int len, input int err_beat);
        logic [31:0] data;
        for (int i = 0; i <= len; i++) begin
            data        = 32'hD000_0000 | (32'(who) << 16) | 32'(i);
            bus.rid     = 4'(who);
            bus.rdata   = data;
            bus.rresp   = (i == err_beat) ? 2'b10 : 2'b00;
            bus.rlast   = (i == len);
            bus.rvalid  = 1'b1;
            #1;
            check_eq("rvalid_sel", 64'(who == 0 ? bus.m0_rvalid : bus.m1_rvalid), 64'd1);
            check_eq("rvalid_other", 64'(who == 0 ? bus.m1_rvalid : bus.m0_rvalid), 64'd0);
            check_eq("rdata", 64'(who == 0 ? bus.m0_rdata : bus.m1_rdata), 64'(data));
            check_eq("rlast", 64'(who == 0 ? bus.m0_rlast : bus.m1_rlast), 64'(i == len));
            tick();
            if (i == err_beat) begin
                check_eq("rd_err_set", 64'(bus.rd_err), 64'd1);
            end
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        check_eq("idle_rready", 64'(bus.rready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_tie [3];
        logic [31:0] a0, a1;

        bus.m0_req_valid = 1'b0; bus.m0_req_addr = 32'd0; bus.m0_req_len = 8'd0; bus.m0_req_size = 3'd2;
        bus.m1_req_valid = 1'b0; bus.m1_req_addr = 32'd0; bus.m1_req_len = 8'd0; bus.m1_req_size = 3'd2;
        bus.arready = 1'b0;
        bus.rid = 4'd0; bus.rdata = 32'd0; bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rvalid = 1'b0;

        // Reset values
        repeat (2) @(posedge aclk);
        #1;
        check_eq("rst_arvalid", 64'(bus.arvalid), 64'd0);
        check_eq("rst_rready", 64'(bus.rready), 64'd0);
        check_eq("rst_araddr", 64'(bus.araddr), 64'd0);
        check_eq("rst_arid", 64'(bus.arid), 64'd0);
        check_eq("rst_rd_err", 64'(bus.rd_err), 64'd0);
        check_eq("rst_req_ready", 64'({bus.m0_req_ready, bus.m1_req_ready}), 64'd0);
        aresetn = 1'b1;
        tick();

        // Ties straight after reset
`ifdef AXI_RD_ARB_RR_EN
        exp_tie[0] = 0; exp_tie[1] = 1; exp_tie[2] = 0;
`else
        exp_tie[0] = 1; exp_tie[1] = 1; exp_tie[2] = 1;
`endif
        for (int t = 0; t < 3; t++) begin
            a0 = 32'h1000_0000 + 32'(t) * 32'h100;
            a1 = 32'h2000_0000 + 32'(t) * 32'h100;
            bus.m0_req_valid = 1'b1; bus.m0_req_addr = a0; bus.m0_req_len = 8'd1;
            bus.m1_req_valid = 1'b1; bus.m1_req_addr = a1; bus.m1_req_len = 8'd1;
            accept(exp_tie[t]);
            if (exp_tie[t] == 0) bus.m0_req_valid = 1'b0;
            else                 bus.m1_req_valid = 1'b0;
            ar_phase(exp_tie[t], (exp_tie[t] == 0) ? a0 : a1, 8'd1, 0);
            r_phase(exp_tie[t], 1, -1);
        end
        bus.m0_req_valid = 1'b0;
        bus.m1_req_valid = 1'b0;
        tick();
        // m0 alone is granted
        bus.m0_req_valid = 1'b1; bus.m0_req_addr = 32'h1000_0800; bus.m0_req_len = 8'd0;
        accept(0);
        bus.m0_req_valid = 1'b0;
        ar_phase(0, 32'h1000_0800, 8'd0, 0);
        r_phase(0, 0, -1);
        check_eq("tie_rd_err_clean", 64'(bus.rd_err), 64'd0);

        // Single m0 burst with arready stalled two cycles
        bus.m0_req_valid = 1'b1; bus.m0_req_addr = 32'h1C00_0000; bus.m0_req_len = 8'd3;
        bus.m0_req_size = 3'd2;
        accept(0);
        // still requesting in AR: ready must not pulse again; late m1 must wait
        bus.m1_req_valid = 1'b1; bus.m1_req_addr = 32'h2FFF_0000;
        #1;
        check_eq("m0_ready_pulse", 64'(bus.m0_req_ready), 64'd0);
        check_eq("m1_wait_in_ar", 64'(bus.m1_req_ready), 64'd0);
        check_eq("arsize", 64'(bus.arsize), 64'd2);
        check_eq("arburst", 64'(bus.arburst), 64'd1);
        check_eq("ar_consts", 64'({bus.arlock, bus.arcache, bus.arprot}), 64'd0);
        bus.m0_req_valid = 1'b0;
        bus.m1_req_valid = 1'b0;
        ar_phase(0, 32'h1C00_0000, 8'd3, 2);
        r_phase(0, 3, -1);
        check_eq("s1_rd_err", 64'(bus.rd_err), 64'd0);
        tick();
        check_eq("dropped_never_granted", 64'(bus.arvalid), 64'd0);

        // Beat with wrong rid while m0 is granted
        bus.m0_req_valid = 1'b1; bus.m0_req_addr = 32'h1C00_1000; bus.m0_req_len = 8'd1;
        accept(0);
        bus.m0_req_valid = 1'b0;
        ar_phase(0, 32'h1C00_1000, 8'd1, 0);
        bus.rid = 4'd1; bus.rdata = 32'hBAD0_BAD0; bus.rlast = 1'b1; bus.rvalid = 1'b1;
        #1;
        check_eq("stray_no_fwd", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        check_eq("stray_consumed", 64'(bus.rready), 64'd1);
        tick();
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        check_eq("stray_rd_err", 64'(bus.rd_err), 64'd1);
        check_eq("stray_stay_r", 64'(bus.rready), 64'd1);
        r_phase(0, 1, -1);

        // Reset during beat 2 of a len=7 burst
        bus.m0_req_valid = 1'b1; bus.m0_req_addr = 32'h1C00_2000; bus.m0_req_len = 8'd7;
        accept(0);
        bus.m0_req_valid = 1'b0;
        ar_phase(0, 32'h1C00_2000, 8'd7, 0);
        for (int i = 0; i < 3; i++) begin
            bus.rid = 4'd0; bus.rdata = 32'h5500_0000 | 32'(i); bus.rlast = 1'b0; bus.rvalid = 1'b1;
            #1;
            check_eq("rstb_rvalid", 64'(bus.m0_rvalid), 64'd1);
            if (i < 2) tick();
        end
        aresetn = 1'b0;
        #1;
        check_eq("rstb_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
        check_eq("rstb_m0_rdata", 64'(bus.m0_rdata), 64'd0);
        check_eq("rstb_rready", 64'(bus.rready), 64'd0);
        check_eq("rstb_rd_err", 64'(bus.rd_err), 64'd0);
        check_eq("rstb_arlen", 64'(bus.arlen), 64'd0);
        bus.rvalid = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        check_eq("post_rst_idle", 64'({bus.arvalid, bus.rready}), 64'd0);

        // New m1 request after reset, error response on beat 1
        bus.m1_req_valid = 1'b1; bus.m1_req_addr = 32'h3000_0040; bus.m1_req_len = 8'd3;
        accept(1);
        bus.m1_req_valid = 1'b0;
        ar_phase(1, 32'h3000_0040, 8'd3, 1);
        check_eq("err_before", 64'(bus.rd_err), 64'd0);
        r_phase(1, 3, 1);
        repeat (3) tick();
        check_eq("err_sticky", 64'(bus.rd_err), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
